l1_writeback_buffer: RTL and testbench
======================================

Name: l1_writeback_buffer

Overview:
- Sits directly downstream of the L1 data cache, between its dirty-eviction path and main memory.
- Accepts dirty victim words from the cache and holds them in a small FIFO. It drains them to memory through a valid/ready handshake.
- Forwards buffered data back to the cache on a lookup hit, so a miss to a recently evicted address never reads stale memory.
- Coalesces repeat evictions of the same address.

Parameters:
- ADDRESS_LENGTH, 32, address width in bits
- DATA_WIDTH, 32, data word width in bits
- DEPTH, 4, number of buffer entries; must be a power of two and at least 2

Ports:
- clk, input, 1, sole clock; all state updates on its rising edge
- reset, input, 1, asynchronous active-low reset
- evict_valid, input, 1, cache presents a dirty victim
- evict_address, input, ADDRESS_LENGTH, victim address
- evict_data, input, DATA_WIDTH, victim data
- evict_ready, output, 1, buffer can accept the victim this cycle
- lookup_address, input, ADDRESS_LENGTH, cache miss address to check against buffered entries
- lookup_hit, output, 1, a valid entry matches lookup_address (combinational)
- lookup_data, output, DATA_WIDTH, data of the youngest matching entry; 0 when no hit
- mem_write_valid, output, 1, head entry is presented to memory
- mem_write_address, output, ADDRESS_LENGTH, head entry address
- mem_write_data, output, DATA_WIDTH, head entry data
- mem_write_ready, input, 1, memory accepts the head entry
- count, output, $clog2(DEPTH)+1, number of valid entries
- full, output, 1, count == DEPTH
- empty, output, 1, count == 0

Behaviour:
- Reset (reset low, asynchronous, takes effect immediately):
  - All entries invalid; entry storage cleared to 0; head and tail pointers 0.
  - Outputs: count=0, empty=1, full=0, mem_write_valid=0, mem_write_address=0, mem_write_data=0, lookup_hit=0, lookup_data=0, evict_ready=1.
  - Reset mid-drain discards all entries, including one being presented to memory.
- Storage: circular FIFO of DEPTH entries {valid, address, data}. Head and tail pointers are $clog2(DEPTH) bits wide and wrap naturally.
- evict_ready = !full. This is combinational from registered state only; it does not depend on mem_write_ready in the same cycle.
- Push: evict_valid && evict_ready at a rising edge.
  - If any valid entry has address == evict_address and that entry is not being popped this cycle: coalesce. Overwrite that entry's data; count unchanged; tail unchanged.
  - Otherwise: allocate at tail, set valid, advance tail, count+1.
- Pop: mem_write_valid && mem_write_ready at a rising edge. Invalidate the head entry, advance head, count-1.
- Push (allocating) and pop in the same cycle: count unchanged, both pointers advance.
- A push that matches only the entry being popped allocates a new entry. It is not lost.
- mem_write_valid = !empty.
  - mem_write_address and mem_write_data come from the head entry registers, with no combinational path from evict_* inputs.
  - Latency: an evict accepted at edge N into an empty buffer appears on mem_write_* after edge N (one cycle).
  - While mem_write_valid=1 and mem_write_ready=0, mem_write_* hold stable.
- Lookup:
  - Combinational compare of lookup_address against all valid entries.
  - With multiple matches the youngest wins; coalescing normally keeps at most one.
  - Sees only registered state: an evict accepted in the same cycle is not visible until the next cycle.
  - An entry popped at edge N is still visible to lookups before edge N.
- Full with evict_valid=1: evict_ready=0, no state change from the push side; the pop side proceeds normally.
- Empty with mem_write_ready=1: no pop, no state change.
- No FSM beyond the FIFO. Occupancy states EMPTY → PARTIAL → FULL are derived from count.

Test Plan:
- Reset then idle: assert reset low mid-cycle → count=0, empty=1, evict_ready=1, mem_write_valid=0 immediately, without waiting for a clock edge.
- Single evict 0x0000_0100/0xDEAD_BEEF with mem_write_ready=0 → next cycle mem_write_valid=1 with that address and data, held stable for 5 cycles. Raise ready → pop; next cycle empty=1.
- Fill with ready=0, pushing addresses 0x10,0x20,0x30,0x40 → full=1, evict_ready=0. A fifth evict to 0x50 is refused. Drain returns 0x10,0x20,0x30,0x40 in order, followed by a pointer-wrap push/pop of 0x50.
- Coalesce: push 0x20/0x1111, then 0x20/0x2222, with ready=0 → count=1. Lookup 0x20 → hit=1, data=0x2222. Lookup 0x24 → hit=0, data=0.
- Simultaneous push and pop at count=2 → count stays 2, order preserved. A push to the head address while the head is popping → new entry allocated, count unchanged, and its data drained later.
- Reset asserted with count=3 during an active mem handshake → all entries gone and mem_write_valid=0 at once. The first evict after reset release is accepted normally.

Source files
------------

// File: rtl/l1_writeback_buffer.sv
// l1_writeback_buffer: small write-back FIFO between the L1 dirty-eviction path
// and main memory. Buffers victim words, drains them in order over a
// valid/ready handshake, forwards buffered data to cache lookups and merges
// repeat evictions of an address that is still waiting in the buffer.

// One buffer slot. It holds {valid, address, data} and does its own address
// compares, so the top level only has to pick among the per-slot results.
module l1_writeback_buffer_entry #(
    parameter int ADDRESS_LENGTH = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_en,
    input  logic                      coal_en,
    input  logic                      pop_en,
    input  logic [ADDRESS_LENGTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [ADDRESS_LENGTH-1:0] lookup_address,
    output logic                      valid,
    output logic [ADDRESS_LENGTH-1:0] address,
    output logic [DATA_WIDTH-1:0]     data,
    output logic                      evict_match,
    output logic                      lookup_match
);

    // Slot state: allocate, merge new data, or retire. The top level never
    // allocates into or merges into the slot it is retiring in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid   <= 1'b0;
            address <= '0;
            data    <= '0;
        end else if (alloc_en) begin
            valid   <= 1'b1;
            address <= wr_address;
            data    <= wr_data;
        end else if (coal_en) begin
            data    <= wr_data;
        end else if (pop_en) begin
            valid   <= 1'b0;
        end
    end

    // Compares use registered slot contents only.
    always_comb begin
        evict_match  = valid && (address == wr_address);
        lookup_match = valid && (address == lookup_address);
    end

endmodule

module l1_writeback_buffer #(
    parameter int ADDRESS_LENGTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        evict_valid,
    input  logic [ADDRESS_LENGTH-1:0]   evict_address,
    input  logic [DATA_WIDTH-1:0]       evict_data,
    output logic                        evict_ready,
    input  logic [ADDRESS_LENGTH-1:0]   lookup_address,
    output logic                        lookup_hit,
    output logic [DATA_WIDTH-1:0]       lookup_data,
    output logic                        mem_write_valid,
    output logic [ADDRESS_LENGTH-1:0]   mem_write_address,
    output logic [DATA_WIDTH-1:0]       mem_write_data,
    input  logic                        mem_write_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    logic [DEPTH-1:0]                     ent_valid;
    logic [DEPTH-1:0][ADDRESS_LENGTH-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     ent_data;
    logic [DEPTH-1:0]                     ent_evict_match;
    logic [DEPTH-1:0]                     ent_lookup_match;
    logic [DEPTH-1:0]                     alloc_en;
    logic [DEPTH-1:0]                     coal_en;
    logic [DEPTH-1:0]                     pop_en;

    logic             push;
    logic             pop;
    logic             alloc;
    logic             coalesce;
    logic             coal_found;
    logic [PTR_W-1:0] coal_idx;

    // Occupancy flags and handshakes; evict_ready depends only on state so the
    // cache never sees a combinational path from the memory side.
    always_comb begin
        full            = (cnt == CNT_W'(DEPTH));
        empty           = (cnt == '0);
        count           = cnt;
        evict_ready     = !full;
        mem_write_valid = !empty;
        push            = evict_valid && evict_ready;
        pop             = mem_write_valid && mem_write_ready;
    end

    // Pick the youngest slot holding the evicted address, skipping the head
    // slot if it is leaving this cycle (that case must allocate, or the data
    // would be dropped along with the retiring entry).
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        coal_found = 1'b0;
        coal_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (ent_evict_match[idx] && !(pop && (idx == head))) begin
                coal_found = 1'b1;
                coal_idx   = idx;
            end
        end
        coalesce = push && coal_found;
        alloc    = push && !coal_found;
    end

    // Forwarding: youngest valid match wins; zero data on a miss.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (ent_lookup_match[idx]) begin
                lookup_hit  = 1'b1;
                lookup_data = ent_data[idx];
            end
        end
    end

    // Head slot drives memory straight from its registers; zero while empty.
    always_comb begin
        mem_write_address = ent_valid[head] ? ent_addr[head] : '0;
        mem_write_data    = ent_valid[head] ? ent_data[head] : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign alloc_en[gi] = alloc    && (tail     == PTR_W'(gi));
            assign coal_en[gi]  = coalesce && (coal_idx == PTR_W'(gi));
            assign pop_en[gi]   = pop      && (head     == PTR_W'(gi));

            l1_writeback_buffer_entry #(
                .ADDRESS_LENGTH (ADDRESS_LENGTH),
                .DATA_WIDTH     (DATA_WIDTH)
            ) u_entry (
                .clk            (clk),
                .reset          (reset),
                .alloc_en       (alloc_en[gi]),
                .coal_en        (coal_en[gi]),
                .pop_en         (pop_en[gi]),
                .wr_address     (evict_address),
                .wr_data        (evict_data),
                .lookup_address (lookup_address),
                .valid          (ent_valid[gi]),
                .address        (ent_addr[gi]),
                .data           (ent_data[gi]),
                .evict_match    (ent_evict_match[gi]),
                .lookup_match   (ent_lookup_match[gi])
            );
        end
    endgenerate

    // Pointers wrap naturally; a merge moves neither pointer nor the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (pop)
                head <= head + PTR_W'(1);
            if (alloc)
                tail <= tail + PTR_W'(1);
            if (alloc && !pop)
                cnt <= cnt + CNT_W'(1);
            else if (pop && !alloc)
                cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_l1_writeback_buffer.sv
// Directed bench for l1_writeback_buffer: a table of per-cycle vectors with
// hand-computed post-edge expectations, plus hand-written sequences for
// pre-edge lookup visibility and asynchronous reset during a drain.
module tb_l1_writeback_buffer;

    logic        clk;
    logic        reset;
    logic        evict_valid;
    logic [31:0] evict_address;
    logic [31:0] evict_data;
    logic        evict_ready;
    logic [31:0] lookup_address;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        mem_write_valid;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_write_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    l1_writeback_buffer #(
        .ADDRESS_LENGTH (32),
        .DATA_WIDTH     (32),
        .DEPTH          (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .evict_valid       (evict_valid),
        .evict_address     (evict_address),
        .evict_data        (evict_data),
        .evict_ready       (evict_ready),
        .lookup_address    (lookup_address),
        .lookup_hit        (lookup_hit),
        .lookup_data       (lookup_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .count             (count),
        .full              (full),
        .empty             (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        rdy;
        logic [31:0] la;
        int          c;
        logic [31:0] ma;
        logic [31:0] md;
        logic        hit;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Full output check; flags, valid and ready follow from the expected count.
    task automatic chk_all(input string tag, input int c, input logic [31:0] ma,
                           input logic [31:0] md, input logic hit, input logic [31:0] ld);
        chk({tag, " count"},       64'(count),             64'(c));
        chk({tag, " empty"},       64'(empty),             64'(c == 0));
        chk({tag, " full"},        64'(full),              64'(c == 4));
        chk({tag, " evict_ready"}, 64'(evict_ready),       64'(c != 4));
        chk({tag, " mem_valid"},   64'(mem_write_valid),   64'(c != 0));
        chk({tag, " mem_addr"},    64'(mem_write_address), 64'(ma));
        chk({tag, " mem_data"},    64'(mem_write_data),    64'(md));
        chk({tag, " lookup_hit"},  64'(lookup_hit),        64'(hit));
        chk({tag, " lookup_data"}, 64'(lookup_data),       64'(ld));
    endtask

    task automatic add(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                       input logic rdy, input logic [31:0] la, input int c,
                       input logic [31:0] ma, input logic [31:0] md,
                       input logic hit, input logic [31:0] ld);
        vec_t v;
        v.ev = ev; v.ea = ea; v.ed = ed; v.rdy = rdy; v.la = la;
        v.c = c; v.ma = ma; v.md = md; v.hit = hit; v.ld = ld;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, take the rising edge, settle just after it.
    task automatic step(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                        input logic rdy, input logic [31:0] la);
        evict_valid     = ev;
        evict_address   = ea;
        evict_data      = ed;
        mem_write_ready = rdy;
        lookup_address  = la;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single evict, held 5 cycles, then drained
        add(1, 32'h100, 32'hDEAD_BEEF, 0, 32'h100, 1, 32'h100, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, 0);
        add(0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
        // Fill to full with memory stalled
        add(1, 32'h10, 32'hA000_0010, 0, 0, 1, 32'h10, 32'hA000_0010, 0, 0);
        add(1, 32'h20, 32'hA000_0020, 0, 0, 2, 32'h10, 32'hA000_0010, 0, 0);
        add(1, 32'h30, 32'hA000_0030, 0, 0, 3, 32'h10, 32'hA000_0010, 0, 0);
        add(1, 32'h40, 32'hA000_0040, 0, 32'h30, 4, 32'h10, 32'hA000_0010, 1, 32'hA000_0030);
        // Fifth evict refused while full
        add(1, 32'h50, 32'hA000_0050, 0, 32'h50, 4, 32'h10, 32'hA000_0010, 0, 0);
        // Still refused while full, but the pop goes ahead
        add(1, 32'h50, 32'hA000_0050, 1, 32'h50, 3, 32'h20, 32'hA000_0020, 0, 0);
        add(0, 0, 0, 1, 0, 2, 32'h30, 32'hA000_0030, 0, 0);
        add(0, 0, 0, 1, 0, 1, 32'h40, 32'hA000_0040, 0, 0);
        add(0, 0, 0, 1, 32'h40, 0, 0, 0, 0, 0);
        // Pointers have wrapped; push into empty (ready high but nothing to pop), then pop
        add(1, 32'h50, 32'hA000_0050, 1, 32'h50, 1, 32'h50, 32'hA000_0050, 1, 32'hA000_0050);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Coalesce
        add(1, 32'h20, 32'h1111, 0, 32'h20, 1, 32'h20, 32'h1111, 1, 32'h1111);
        add(1, 32'h20, 32'h2222, 0, 32'h20, 1, 32'h20, 32'h2222, 1, 32'h2222);
        add(0, 0, 0, 0, 32'h24, 1, 32'h20, 32'h2222, 0, 0);
        // Simultaneous push and pop at count 2
        add(1, 32'h60, 32'h6666, 0, 0, 2, 32'h20, 32'h2222, 0, 0);
        add(1, 32'h70, 32'h7777, 1, 32'h70, 2, 32'h60, 32'h6666, 1, 32'h7777);
        // Push to the head address while the head pops: allocates a new entry
        add(1, 32'h60, 32'hAAAA, 1, 32'h60, 2, 32'h70, 32'h7777, 1, 32'hAAAA);
        add(0, 0, 0, 1, 0, 1, 32'h60, 32'hAAAA, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        evict_valid = 0; evict_address = 0; evict_data = 0;
        mem_write_ready = 0; lookup_address = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].rdy, vecs[i].la);
            chk_all($sformatf("row%0d", i), vecs[i].c, vecs[i].ma, vecs[i].md,
                    vecs[i].hit, vecs[i].ld);
        end

        // An entry being popped is still visible to lookups before the edge
        step(1, 32'h80, 32'h8888, 0, 32'h80);
        chk_all("pop_vis setup", 1, 32'h80, 32'h8888, 1, 32'h8888);
        evict_valid = 0; mem_write_ready = 1; lookup_address = 32'h80;
        #2;
        chk("pop_vis pre-edge hit",  64'(lookup_hit),  64'(1));
        chk("pop_vis pre-edge data", 64'(lookup_data), 64'(32'h8888));
        @(posedge clk);
        #1;
        chk_all("pop_vis post-edge", 0, 0, 0, 0, 0);

        // Same-cycle evict is not visible to lookup until after the edge
        evict_valid = 1; evict_address = 32'h88; evict_data = 32'h8899;
        mem_write_ready = 0; lookup_address = 32'h88;
        #2;
        chk("same-cycle evict invisible", 64'(lookup_hit), 64'(0));
        @(posedge clk);
        #1;
        chk_all("same-cycle evict landed", 1, 32'h88, 32'h8899, 1, 32'h8899);
        step(0, 0, 0, 1, 0);
        chk_all("same-cycle evict drained", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-handshake with three entries
        step(1, 32'h90, 32'h9090, 0, 0);
        step(1, 32'hA0, 32'hA0A0, 0, 0);
        step(1, 32'hB0, 32'hB0B0, 0, 32'h90);
        chk_all("pre-reset", 3, 32'h90, 32'h9090, 1, 32'h9090);
        evict_valid = 0; mem_write_ready = 1; lookup_address = 32'h90;
        #2;
        reset = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("reset held", 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(1, 32'hC0, 32'hCCCC, 0, 32'hC0);
        chk_all("post-reset evict", 1, 32'hC0, 32'hCCCC, 1, 32'hCCCC);
        step(0, 0, 0, 1, 32'hC0);
        chk_all("post-reset drain", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
